// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts ALU requests, drives the ALU, sequences MULT/MULTU as 32 shift-add steps.
// Latency: ALU ops respond 2 cycles after the accept cycle, multiply 34, illegal codes 1.
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
// Optional: define ALU_ISSUE_MUL_EARLY_EXIT_EN to finish multiply once the remaining multiplier bits are zero.
module alu_issue_ctrl #(
    parameter int unsigned          DATA_W         = 32,
    parameter logic [DATA_W-1:0]    ILLEGAL_RESULT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_hi,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_illegal,
    output logic [DATA_W-1:0] alu_operand0,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_FIX, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, mplier_q, mplier_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d, rsp_hi_q, rsp_hi_d;
    logic                rsp_zero_q, rsp_zero_d, rsp_ovf_q, rsp_ovf_d, rsp_ill_q, rsp_ill_d;

    logic                is_mult, neg_prod, carry;
    logic [DATA_W-1:0]   mcand, mplier_init;
    logic [2*DATA_W-1:0] shifted, product, product_fix;

    function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_result   = rsp_result_q;
    assign rsp_hi       = rsp_hi_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_illegal  = rsp_ill_q;

    // State and datapath registers; synchronous reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_hi_q     <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            rsp_result_q <= '0;
            rsp_hi_q     <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_ill_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_hi_q     <= acc_hi_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_ill_q    <= rsp_ill_d;
        end
    end

    // Next-state, ALU drive and response capture.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_hi_d     = acc_hi_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_ill_d    = rsp_ill_q;
        alu_operand0 = '0;
        alu_operand1 = '0;
        alu_control  = OP_ADD;

        is_mult     = (op_q == OP_MULT);
        mcand       = is_mult ? abs_w(a_q) : a_q;
        mplier_init = (req_op == OP_MULT) ? abs_w(req_b) : req_b;
        // Unsigned carry out of acc_hi + mcand, recovered from the 32-bit ALU sum.
        carry       = (acc_hi_q[DATA_W-1] & mcand[DATA_W-1])
                    | ((acc_hi_q[DATA_W-1] ^ mcand[DATA_W-1]) & ~alu_result[DATA_W-1]);
        shifted     = mplier_q[0] ? {carry, alu_result, mplier_q[DATA_W-1:1]}
                                  : {1'b0, acc_hi_q, mplier_q[DATA_W-1:1]};
        product     = {acc_hi_q, mplier_q};
        neg_prod    = is_mult & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        product_fix = neg_prod ? (~product + 1'b1) : product;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    acc_hi_d = '0;
                    mplier_d = mplier_init;
                    cnt_d    = '0;
                    if (req_op >= 4'b1010) begin
                        rsp_result_d = ILLEGAL_RESULT;
                        rsp_hi_d     = '0;
                        rsp_zero_d   = (ILLEGAL_RESULT == '0);
                        rsp_ovf_d    = 1'b0;
                        rsp_ill_d    = 1'b1;
                        state_d      = S_RESP;
                    end else if (req_op == OP_MULT || req_op == OP_MULTU) begin
                        state_d = S_MUL;
`ifdef ALU_ISSUE_MUL_EARLY_EXIT_EN
                        if (mplier_init == '0) state_d = S_FIX;
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_operand0 = a_q;
                alu_operand1 = b_q;
                alu_control  = op_q;
                rsp_result_d = alu_result;
                rsp_hi_d     = '0;
                rsp_zero_d   = alu_zero;
                rsp_ovf_d    = alu_overflow & (op_q == OP_ADD || op_q == OP_SUB);
                rsp_ill_d    = 1'b0;
                state_d      = S_RESP;
            end
            S_MUL: begin
                alu_operand0 = acc_hi_q;
                alu_operand1 = mcand;
                alu_control  = OP_ADD;
                {acc_hi_d, mplier_d} = shifted;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
`ifdef ALU_ISSUE_MUL_EARLY_EXIT_EN
                // Unused multiplier bits sit in the low 31-cnt positions after this step.
                if ((shifted[DATA_W-1:0] & ({1'b0, {(DATA_W-1){1'b1}}} >> cnt_q)) == '0) begin
                    {acc_hi_d, mplier_d} = shifted >> (5'd31 - cnt_q);
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                rsp_hi_d     = product_fix[2*DATA_W-1:DATA_W];
                rsp_result_d = product_fix[DATA_W-1:0];
                rsp_zero_d   = (product_fix == '0);
                rsp_ovf_d    = 1'b0;
                rsp_ill_d    = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
